pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction decoder.
- Holds the PC, drives the instruction-memory address and gates instruction validity into the decoder.
- Consumes the decoder's jump/done/reset controls and the ALU's passed-through branch immediate to compute the next PC.
- Owns the start/done handshake with the testbench/top level.

---
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC/fetch sequencer feeding the decoder; optional cycle counter under PC_FETCH_CYCLE_COUNT_EN.
// Latency: next PC appears on instr_addr one cycle after the controlling decoder/start inputs.
// Backpressure: none; the decoder is assumed to consume one instruction per cycle while in RUN.
module pc_fetch_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             rel_jump,
    input  logic             abs_jump,
    input  logic [OFF_W-1:0] jump_operand,
    input  logic             done_i,
    input  logic             soft_reset,
    output logic [PC_W-1:0]  instr_addr,
    output logic             instr_valid,
    output logic             done,
`ifdef PC_FETCH_CYCLE_COUNT_EN
    output logic [31:0]      cycle_count,
`endif
    output logic [PC_W-1:0]  pc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] abs_tgt;
    logic            start_accept;

    // Offsets narrower than the PC are sign-extended (relative) or zero-extended
    // (absolute); wider ones are simply truncated to the PC width.
    generate
        if (OFF_W < PC_W) begin : g_ext
            assign rel_off = {{(PC_W-OFF_W){jump_operand[OFF_W-1]}}, jump_operand};
            assign abs_tgt = {{(PC_W-OFF_W){1'b0}}, jump_operand};
        end else begin : g_trunc
            assign rel_off = jump_operand[PC_W-1:0];
            assign abs_tgt = jump_operand[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        start_accept = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    start_accept = 1'b1;
                    pc_d         = start_addr;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (done_i) begin
                    state_d = S_HALTED;
                end else if (soft_reset) begin
                    pc_d = start_addr;
                end else if (rel_jump) begin
                    pc_d = pc + rel_off;
                end else if (abs_jump) begin
                    pc_d = abs_tgt;
                end else begin
                    pc_d = pc + PC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc      <= '0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

    assign instr_addr  = pc;
    assign instr_valid = (state_q == S_RUN);
    assign done        = (state_q == S_HALTED);

`ifdef PC_FETCH_CYCLE_COUNT_EN
    // Counts every RUN cycle, including the one in which FIN is seen.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            cycle_count <= '0;
        end else if (start_accept) begin
            cycle_count <= '0;
        end else if ((state_q == S_RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (PC_W=10, OFF_W=8).
module tb_pc_fetch_unit;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] start_addr;
    logic       rel_jump;
    logic       abs_jump;
    logic [7:0] jump_operand;
    logic       done_i;
    logic       soft_reset;
    logic [9:0] instr_addr;
    logic       instr_valid;
    logic       done;
    logic [9:0] pc;
`ifdef PC_FETCH_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pc_fetch_unit #(.PC_W(10), .OFF_W(8)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .rel_jump    (rel_jump),
        .abs_jump    (abs_jump),
        .jump_operand(jump_operand),
        .done_i      (done_i),
        .soft_reset  (soft_reset),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .done        (done),
`ifdef PC_FETCH_CYCLE_COUNT_EN
        .cycle_count (cycle_count),
`endif
        .pc          (pc)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; rel_jump = 0; abs_jump = 0; done_i = 0; soft_reset = 0; jump_operand = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 0; idle_inputs(); start_addr = 10'd0;
        step(); step();
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset_n = 1;
        step();
        checks++; if (pc !== 10'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got pc=%0d valid=%b exp pc=0 valid=0", pc, instr_valid); end
    endtask

    task automatic test_sequential();
        start = 1; start_addr = 10'd5;
        step();
        start = 0;
        checks++; if (pc !== 10'd5 || instr_valid !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL start_pc got pc=%0d valid=%b done=%b exp pc=5 valid=1 done=0", pc, instr_valid, done); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (pc !== 10'(5 + i) || instr_addr !== 10'(5 + i)) begin failures++; $display("FAIL seq_pc%0d got pc=%0d addr=%0d exp=%0d", i, pc, instr_addr, 5 + i); end
        end
        // start is ignored while running
        start = 1; start_addr = 10'd99;
        step();
        start = 0;
        checks++; if (pc !== 10'd10) begin failures++; $display("FAIL start_in_run got=%0d exp=10", pc); end
    endtask

    task automatic test_jumps();
        soft_reset = 1; start_addr = 10'd20; step(); soft_reset = 0;
        checks++; if (pc !== 10'd20 || instr_valid !== 1'b1) begin failures++; $display("FAIL soft_reset_20 got=%0d exp=20", pc); end
        rel_jump = 1; jump_operand = 8'hFD; step();
        checks++; if (pc !== 10'd17) begin failures++; $display("FAIL rel_neg got=%0d exp=17", pc); end
        rel_jump = 0; soft_reset = 1; step(); soft_reset = 0;
        rel_jump = 1; jump_operand = 8'h03; step(); rel_jump = 0;
        checks++; if (pc !== 10'd23) begin failures++; $display("FAIL rel_pos got=%0d exp=23", pc); end
        soft_reset = 1; start_addr = 10'd1023; step(); soft_reset = 0;
        checks++; if (pc !== 10'd1023) begin failures++; $display("FAIL soft_reset_1023 got=%0d exp=1023", pc); end
        step();
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL inc_wrap got=%0d exp=0", pc); end
        rel_jump = 1; jump_operand = 8'hFD; step();
        checks++; if (pc !== 10'd1021) begin failures++; $display("FAIL rel_wrap got=%0d exp=1021", pc); end
        jump_operand = 8'h00; step(); step();
        checks++; if (pc !== 10'd1021) begin failures++; $display("FAIL self_loop got=%0d exp=1021", pc); end
        rel_jump = 0; abs_jump = 1; jump_operand = 8'h80; step(); abs_jump = 0;
        checks++; if (pc !== 10'd128) begin failures++; $display("FAIL abs_zext got=%0d exp=128", pc); end
    endtask

    task automatic test_priority();
        soft_reset = 1; start_addr = 10'd10; step(); soft_reset = 0;
        rel_jump = 1; abs_jump = 1; jump_operand = 8'h02; step();
        checks++; if (pc !== 10'd12) begin failures++; $display("FAIL rel_over_abs got=%0d exp=12", pc); end
        soft_reset = 1; start_addr = 10'd30; step();
        checks++; if (pc !== 10'd30) begin failures++; $display("FAIL to_30 got=%0d exp=30", pc); end
        start_addr = 10'd7; step();
        soft_reset = 0; rel_jump = 0; abs_jump = 0;
        checks++; if (pc !== 10'd7 || instr_valid !== 1'b1) begin failures++; $display("FAIL soft_over_rel got pc=%0d valid=%b exp pc=7 valid=1", pc, instr_valid); end
    endtask

    task automatic test_done();
        soft_reset = 1; start_addr = 10'd40; step(); soft_reset = 0;
        done_i = 1; rel_jump = 1; jump_operand = 8'h05; step();
        checks++; if (pc !== 10'd40 || done !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL halt got pc=%0d done=%b valid=%b exp pc=40 done=1 valid=0", pc, done, instr_valid); end
        soft_reset = 1; step();
        idle_inputs();
        checks++; if (pc !== 10'd40 || done !== 1'b1) begin failures++; $display("FAIL halted_hold got pc=%0d done=%b exp pc=40 done=1", pc, done); end
        start = 1; start_addr = 10'd2; step(); start = 0;
        checks++; if (pc !== 10'd2 || done !== 1'b0 || instr_valid !== 1'b1) begin failures++; $display("FAIL restart got pc=%0d done=%b valid=%b exp pc=2 done=0 valid=1", pc, done, instr_valid); end
        step();
        checks++; if (pc !== 10'd3) begin failures++; $display("FAIL restart_inc got=%0d exp=3", pc); end
    endtask

    task automatic test_reset_mid_run();
        soft_reset = 1; start_addr = 10'd55; step(); soft_reset = 0;
        checks++; if (pc !== 10'd55) begin failures++; $display("FAIL to_55 got=%0d exp=55", pc); end
        reset_n = 0; rel_jump = 1; start = 1; jump_operand = 8'h04; step();
        checks++; if (pc !== 10'd0 || instr_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_reset got pc=%0d valid=%b done=%b exp 0/0/0", pc, instr_valid, done); end
        reset_n = 1; start = 0; abs_jump = 1; soft_reset = 1; done_i = 1; step(); step();
        idle_inputs();
        checks++; if (pc !== 10'd0 || instr_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_ignores_dec got pc=%0d valid=%b done=%b exp 0/0/0", pc, instr_valid, done); end
    endtask

`ifdef PC_FETCH_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL cc_reset got=%0d exp=0", cycle_count); end
        start = 1; start_addr = 10'd0; step(); start = 0;
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL cc_start got=%0d exp=0", cycle_count); end
        for (int i = 0; i < 6; i++) step();
        soft_reset = 1; step(); soft_reset = 0; // soft reset counts, does not clear
        done_i = 1; step(); done_i = 0;
        checks++; if (cycle_count !== 32'd8 || done !== 1'b1) begin failures++; $display("FAIL cc_done got=%0d exp=8", cycle_count); end
        step(); step();
        checks++; if (cycle_count !== 32'd8) begin failures++; $display("FAIL cc_hold got=%0d exp=8", cycle_count); end
        start = 1; step(); start = 0;
        for (int i = 0; i < 6; i++) step();
        done_i = 1; step(); done_i = 0;
        checks++; if (cycle_count !== 32'd7) begin failures++; $display("FAIL cc_seven got=%0d exp=7", cycle_count); end
        start = 1; step(); start = 0;
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL cc_clear got=%0d exp=0", cycle_count); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset_n = 0; start_addr = 10'd0;
        test_reset();
        test_sequential();
        test_jumps();
        test_priority();
        test_done();
        test_reset_mid_run();
`ifdef PC_FETCH_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
